pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch / PC sequencing unit: fetches one word per instruction,
// presents it for decode, and resolves branches when execution completes.
module pc_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [2:0]  CondJump,
  input  logic        UncondJump,
  input  logic [31:0] BranchTarget,
  input  logic        ZeroFlag,
  input  logic        SignFlag,
  input  logic        CarryFlag,
  input  logic        exec_done,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [5:0] OPC_HALT = 6'b111111;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc_next;
  logic [31:0] w_instr_next;
  logic [31:0] w_pc_plus4;
  logic        r_imem_req;
  logic        r_instr_valid;
  logic        r_halted;

  // Condition codes 000, 110 and 111 never take a conditional branch.
  function automatic logic branch_taken(
    input logic [2:0] cj,
    input logic       uj,
    input logic       z,
    input logic       s,
    input logic       c
  );
    logic t;
    case (cj)
      3'b001:  t = s;
      3'b010:  t = z;
      3'b011:  t = ~z;
      3'b100:  t = c;
      3'b101:  t = ~c;
      default: t = 1'b0;
    endcase
    return uj | t;
  endfunction

  assign w_pc_plus4 = r_pc + 32'd4;

  // Next-state and next-datapath decode.
  always_comb begin
    w_next       = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_instr_next = imem_rdata;
          w_next       = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (r_instr[31:26] == OPC_HALT) begin
          w_next = S_HALT;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          if (branch_taken(CondJump, UncondJump, ZeroFlag, SignFlag, CarryFlag)) begin
            w_pc_next = {BranchTarget[31:2], 2'b00};
          end else begin
            w_pc_next = w_pc_plus4;
          end
          w_next = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= 32'd0;
      r_instr       <= 32'd0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_pc          <= w_pc_next;
      r_instr       <= w_instr_next;
      r_imem_req    <= (w_next == S_FETCH);
      r_instr_valid <= (w_next == S_DECODE);
      r_halted      <= (w_next == S_HALT);
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halted      = r_halted;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: reset, fetch handshake,
// branch condition sweep, PC wrap, HALT and asynchronous reset recovery.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [2:0]  CondJump = 3'd0;
  logic        UncondJump = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic        ZeroFlag = 1'b0;
  logic        SignFlag = 1'b0;
  logic        CarryFlag = 1'b0;
  logic        exec_done = 1'b0;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .CondJump(CondJump), .UncondJump(UncondJump), .BranchTarget(BranchTarget),
    .ZeroFlag(ZeroFlag), .SignFlag(SignFlag), .CarryFlag(CarryFlag),
    .exec_done(exec_done), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a fetch, acks it, walks through DECODE/EXEC and
  // retires the instruction with the given branch inputs.
  task automatic run_instr(input logic [31:0] rdata, input logic [2:0] cj,
                           input logic uj, input logic z, input logic s,
                           input logic c, input logic [31:0] tgt,
                           output bit ok);
    int waited;
    waited = 0;
    while (!imem_req && waited < 20) begin
      tick();
      waited++;
    end
    ok = imem_req;
    if (ok) begin
      imem_ack = 1'b1; imem_rdata = rdata;
      tick();
      imem_ack = 1'b0;
      tick();
      CondJump = cj; UncondJump = uj; ZeroFlag = z; SignFlag = s; CarryFlag = c;
      BranchTarget = tgt; exec_done = 1'b1;
      tick();
      exec_done = 1'b0; CondJump = 3'd0; UncondJump = 1'b0;
      ZeroFlag = 1'b0; SignFlag = 1'b0; CarryFlag = 1'b0;
    end
  endtask

  function automatic logic exp_taken(input logic [2:0] cj, input logic uj,
                                     input logic z, input logic s, input logic c);
    logic t;
    t = 1'b0;
    if (cj == 3'b001 && s) t = 1'b1;
    if (cj == 3'b010 && z) t = 1'b1;
    if (cj == 3'b011 && !z) t = 1'b1;
    if (cj == 3'b100 && c) t = 1'b1;
    if (cj == 3'b101 && !c) t = 1'b1;
    return t || uj;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({imem_req, instr_valid, halted, pc, instr} !== {3'b000, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset_state: req=%b valid=%b halted=%b pc=%h instr=%h, want all zero",
               imem_req, instr_valid, halted, pc, instr);
    end
    rst_n = 1'b1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++; $display("FAIL reset_release_idle: req=%b want 0", imem_req);
    end
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_bad++;
      $display("FAIL first_req: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_first_fetch();
    tick(); tick();
    n_cmp++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL fetch_wait: req=%b valid=%b want 1/0", imem_req, instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0400_0000;
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b1 || opcode !== 6'b000001 || pc !== 32'd0 ||
        instr !== 32'h0400_0000 || imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL decode: valid=%b opc=%b pc=%h instr=%h req=%b want 1/000001/0/04000000/0",
               instr_valid, opcode, pc, instr, imem_req);
    end
    tick();
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc_plus4 !== 32'd4) begin
      n_bad++;
      $display("FAIL exec_hold: valid=%b req=%b pc_plus4=%h want 0/0/4",
               instr_valid, imem_req, pc_plus4);
    end
    tick(); tick();
    n_cmp++;
    if (pc !== 32'd0 || imem_req !== 1'b0) begin
      n_bad++; $display("FAIL exec_wait: pc=%h req=%b want 0/0", pc, imem_req);
    end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin
      n_bad++; $display("FAIL next_fetch: req=%b addr=%h want 1/00000004", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch();
    bit ok;
    run_instr(32'd0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0103, ok);
    n_cmp++;
    if (!ok || imem_addr !== 32'h0000_0100) begin
      n_bad++; $display("FAIL beq_taken: ok=%b addr=%h want 00000100", ok, imem_addr);
    end
    run_instr(32'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0103, ok);
    n_cmp++;
    if (!ok || imem_addr !== 32'h0000_0104) begin
      n_bad++; $display("FAIL beq_not_taken: ok=%b addr=%h want 00000104", ok, imem_addr);
    end
  endtask

  task automatic test_cond_sweep();
    bit ok;
    logic [31:0] start, tgt, want;
    logic [2:0] f;
    int idx;
    idx = 0;
    for (int uj = 0; uj < 2; uj++) begin
      for (int cj = 0; cj < 8; cj++) begin
        for (int fl = 0; fl < 8; fl++) begin
          f = fl[2:0];
          start = imem_addr;
          tgt = 32'h8000_0003 + (idx << 4);
          want = exp_taken(cj[2:0], uj[0], f[0], f[1], f[2]) ? (tgt & 32'hFFFF_FFFC)
                                                              : start + 32'd4;
          run_instr(32'h0800_0000, cj[2:0], uj[0], f[0], f[1], f[2], tgt, ok);
          n_cmp++;
          if (!ok || imem_addr !== want) begin
            n_bad++;
            $display("FAIL sweep uj=%0d cj=%0d zsc=%b%b%b: addr=%h want %h",
                     uj, cj, f[0], f[1], f[2], imem_addr, want);
          end
          idx++;
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    run_instr(32'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, ok);
    n_cmp++;
    if (!ok || imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0) begin
      n_bad++;
      $display("FAIL wrap_setup: addr=%h pc_plus4=%h want FFFFFFFC/00000000",
               imem_addr, pc_plus4);
    end
    run_instr(32'd0, 3'b110, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, ok);
    n_cmp++;
    if (!ok || imem_addr !== 32'd0) begin
      n_bad++; $display("FAIL wrap: addr=%h want 00000000", imem_addr);
    end
  endtask

  task automatic test_halt();
    logic [31:0] hpc;
    int bad_cycles;
    hpc = imem_addr;
    imem_ack = 1'b1; imem_rdata = 32'hFC00_0000;
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b1 || opcode !== 6'b111111) begin
      n_bad++; $display("FAIL halt_decode: valid=%b opc=%b want 1/111111", instr_valid, opcode);
    end
    tick();
    n_cmp++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_enter: halted=%b req=%b valid=%b want 1/0/0", halted, imem_req, instr_valid);
    end
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      exec_done = i[0]; imem_ack = ~i[0]; UncondJump = 1'b1;
      BranchTarget = 32'h0000_0800; imem_rdata = 32'h0000_1234;
      tick();
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          pc !== hpc || instr !== 32'hFC00_0000) bad_cycles++;
    end
    exec_done = 1'b0; imem_ack = 1'b0; UncondJump = 1'b0;
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++; $display("FAIL halt_hold: %0d bad cycles want 0", bad_cycles);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_instr(32'h1111_1111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, ok);
    n_cmp++;
    if (!ok || imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
      n_bad++; $display("FAIL pre_reset_fetch: req=%b addr=%h want 1/00000200", imem_req, imem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req, instr_valid, halted, pc, instr} !== {3'b000, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL async_clear: req=%b valid=%b halted=%b pc=%h instr=%h want zeros",
               imem_req, instr_valid, halted, pc, instr);
    end
    #1;
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hFC00_0000;
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr !== 32'd0 || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stale_ack: req=%b addr=%h instr=%h valid=%b want 1/0/0/0",
               imem_req, imem_addr, instr, instr_valid);
    end
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_fetch: req=%b valid=%b halted=%b want 1/0/0", imem_req, instr_valid, halted);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_branch();
    test_cond_sweep();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
